// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and expected-function helper for the gate response checker
package gate_check_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, HOLD} chk_state_t;
  typedef enum logic [1:0] {F_AND, F_NAND, F_OR, F_XOR} gate_fn_t;

  function automatic logic expected_out(gate_fn_t fn, logic a, logic b);
    logic r;
    case (fn)
      F_AND:   r = a & b;
      F_NAND:  r = ~(a & b);
      F_OR:    r = a | b;
      F_XOR:   r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - settles, checks and glitch-monitors a two-input gate's response
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic             glitch_flag,
  output logic [2:0]       first_err,
  output logic             settled
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] CNT_ONE     = SW'(1);

  logic             r_a_q, r_b_q, r_y_q, r_y_prev;
  logic [1:0]       r_mode_q, r_mode_prev, r_ab_prev;
  chk_state_t       r_state;
  logic [SW-1:0]    r_cnt;
  logic             r_err_flag, r_glitch_flag;
  logic [2:0]       r_first_err;

  logic             w_change, w_exp;
  logic             w_pass_inc, w_err_inc, w_glitch;
  chk_state_t       w_next_state;
  logic [SW-1:0]    w_next_cnt;

  assign w_change = ({r_a_q, r_b_q} != r_ab_prev) || (r_mode_q != r_mode_prev);
  assign w_exp    = expected_out(gate_fn_t'(r_mode_q), r_a_q, r_b_q);

  // An input or mode change always restarts settling, which also masks any y edge in that cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pass_inc   = 1'b0;
    w_err_inc    = 1'b0;
    w_glitch     = 1'b0;
    if (!en) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = SETTLE;
          w_next_cnt   = SETTLE_LOAD;
        end
        SETTLE: begin
          if (w_change)          w_next_cnt   = SETTLE_LOAD;
          else if (r_cnt == '0)  w_next_state = CHECK;
          else                   w_next_cnt   = r_cnt - CNT_ONE;
        end
        CHECK: begin
          if (w_change) begin
            w_next_state = SETTLE;
            w_next_cnt   = SETTLE_LOAD;
          end else begin
            w_next_state = HOLD;
            w_pass_inc   = (r_y_q == w_exp);
            w_err_inc    = (r_y_q != w_exp);
          end
        end
        HOLD: begin
          if (w_change) begin
            w_next_state = SETTLE;
            w_next_cnt   = SETTLE_LOAD;
          end else if (r_y_q != r_y_prev) begin
            w_glitch  = 1'b1;
            w_err_inc = 1'b1;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_q         <= 1'b0;
      r_b_q         <= 1'b0;
      r_y_q         <= 1'b0;
      r_mode_q      <= 2'b00;
      r_ab_prev     <= 2'b00;
      r_y_prev      <= 1'b0;
      r_mode_prev   <= 2'b00;
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_err_flag    <= 1'b0;
      r_glitch_flag <= 1'b0;
      r_first_err   <= 3'b000;
    end else begin
      r_a_q       <= a;
      r_b_q       <= b;
      r_y_q       <= y;
      r_mode_q    <= mode;
      r_ab_prev   <= {r_a_q, r_b_q};
      r_y_prev    <= r_y_q;
      r_mode_prev <= r_mode_q;
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      if (w_err_inc) begin
        r_err_flag <= 1'b1;
        if (!r_err_flag) r_first_err <= {r_a_q, r_b_q, r_y_q};
      end
      if (w_glitch) r_glitch_flag <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pass_inc),
    .count (pass_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err_inc),
    .count (err_count)
  );

  assign err_flag    = r_err_flag;
  assign glitch_flag = r_glitch_flag;
  assign first_err   = r_first_err;
  assign settled     = (r_state == HOLD);

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - vector table plus corner sequences for gate_response_checker
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       reset, en, a, b, y;
  logic [1:0] mode;

  logic [7:0] pass_count, err_count;
  logic       err_flag, glitch_flag, settled;
  logic [2:0] first_err;

  logic [2:0] sat_pass, sat_err;
  logic       sat_eflag, sat_gflag, sat_settled;
  logic [2:0] sat_first;

  logic [7:0] s0_pass, s0_err;
  logic       s0_eflag, s0_gflag, s0_settled;
  logic [2:0] s0_first;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_response_checker dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .y(y),
    .pass_count(pass_count), .err_count(err_count), .err_flag(err_flag),
    .glitch_flag(glitch_flag), .first_err(first_err), .settled(settled)
  );

  gate_response_checker #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .y(y),
    .pass_count(sat_pass), .err_count(sat_err), .err_flag(sat_eflag),
    .glitch_flag(sat_gflag), .first_err(sat_first), .settled(sat_settled)
  );

  gate_response_checker #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .y(y),
    .pass_count(s0_pass), .err_count(s0_err), .err_flag(s0_eflag),
    .glitch_flag(s0_gflag), .first_err(s0_first), .settled(s0_settled)
  );

  typedef struct {
    bit         rst;
    logic [1:0] mode;
    logic       a, b, y;
    int         pass;
    int         err;
    logic       eflag;
    logic [2:0] first;
    logic       settled;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Holds reset for two cycles under random inputs and checks every output is cleared.
  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b1;
    a     = 1'($urandom_range(0, 1));
    b     = 1'($urandom_range(0, 1));
    y     = 1'($urandom_range(0, 1));
    mode  = 2'($urandom_range(0, 3));
    ticks(2);
    chk("rst_pass", int'(pass_count), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_eflag", int'(err_flag), 0);
    chk("rst_gflag", int'(glitch_flag), 0);
    chk("rst_first", int'(first_err), 0);
    chk("rst_settled", int'(settled), 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'd0; a = 1'b0; b = 1'b0; y = 1'b0;

    //           rst  mode  a     b     y     pass err eflag first   settled
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1,   0,  1'b0, 3'b000, 1'b1};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2,   0,  1'b0, 3'b000, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3,   0,  1'b0, 3'b000, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4,   0,  1'b0, 3'b000, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 5,   0,  1'b0, 3'b000, 1'b1};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0,   1,  1'b1, 3'b000, 1'b1};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 0,   2,  1'b1, 3'b000, 1'b1};
    vecs[7]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1,   0,  1'b0, 3'b000, 1'b1};
    vecs[8]  = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 2,   0,  1'b0, 3'b000, 1'b1};
    vecs[9]  = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 3,   0,  1'b0, 3'b000, 1'b1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 3,   1,  1'b1, 3'b001, 1'b1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4,   1,  1'b1, 3'b001, 1'b1};

    ticks(2);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) do_reset();
      mode = vecs[i].mode; a = vecs[i].a; b = vecs[i].b; y = vecs[i].y;
      reset = 1'b0;
      ticks(6);
      chk($sformatf("vec%0d_pass", i), int'(pass_count), vecs[i].pass);
      chk($sformatf("vec%0d_err", i), int'(err_count), vecs[i].err);
      chk($sformatf("vec%0d_eflag", i), int'(err_flag), int'(vecs[i].eflag));
      chk($sformatf("vec%0d_first", i), int'(first_err), int'(vecs[i].first));
      chk($sformatf("vec%0d_settled", i), int'(settled), int'(vecs[i].settled));
      chk($sformatf("vec%0d_gflag", i), int'(glitch_flag), 0);
    end

    // Glitch: y pulses low for one cycle while OR(1,0) is settled.
    do_reset();
    mode = 2'd2; a = 1'b1; b = 1'b0; y = 1'b1;
    reset = 1'b0;
    ticks(6);
    chk("gl_settled_before", int'(settled), 1);
    y = 1'b0;
    tick();
    y = 1'b1;
    ticks(4);
    chk("gl_gflag", int'(glitch_flag), 1);
    chk("gl_err", int'(err_count), 2);
    chk("gl_eflag", int'(err_flag), 1);
    chk("gl_first", int'(first_err), 3'b100);
    chk("gl_pass", int'(pass_count), 1);
    chk("gl_settled_after", int'(settled), 1);

    // Fast toggling never settles; dropping en mid-SETTLE parks the FSM in IDLE.
    do_reset();
    mode = 2'd0; a = 1'b0; b = 1'b0; y = 1'b0;
    reset = 1'b0;
    ticks(6);
    chk("tg_pass_start", int'(pass_count), 1);
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 1);
      b = (i % 2 == 0);
      tick();
    end
    chk("tg_pass_toggled", int'(pass_count), 1);
    chk("tg_settled_toggled", int'(settled), 0);
    ticks(2);
    en = 1'b0;
    ticks(10);
    chk("en_pass_retained", int'(pass_count), 1);
    chk("en_err_retained", int'(err_count), 0);
    chk("en_settled", int'(settled), 0);
    en = 1'b1;
    ticks(6);
    chk("en_pass_resumed", int'(pass_count), 2);
    chk("en_settled_resumed", int'(settled), 1);

    // Check latency: SETTLE_CYCLES=0 counts two cycles earlier than the default of 2.
    do_reset();
    mode = 2'd0; a = 1'b0; b = 1'b0; y = 1'b0;
    reset = 1'b0;
    ticks(6);
    a = 1'b1; b = 1'b1; y = 1'b1;
    ticks(3);
    chk("lat_s0_before", int'(s0_pass), 1);
    tick();
    chk("lat_s0_after", int'(s0_pass), 2);
    chk("lat_main_e3", int'(pass_count), 1);
    tick();
    chk("lat_main_e4", int'(pass_count), 1);
    tick();
    chk("lat_main_e5", int'(pass_count), 2);
    chk("lat_main_err", int'(err_count), 0);

    // Saturation: nine passing vectors against a 3-bit counter.
    do_reset();
    mode = 2'd0; y = 1'b0; a = 1'b0; b = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = (i % 2 == 1);
      b = (i % 2 == 1);
      y = (i % 2 == 1);
      ticks(6);
    end
    chk("sat_pass", int'(sat_pass), 7);
    chk("sat_err", int'(sat_err), 0);
    chk("sat_main_pass", int'(pass_count), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
